gcn_matrix_fetch: RTL

//  Read initiator for the GCN matrix memory port. On start, fetches all WEIGHT_COLS weight

---
 rtl/gcn_matrix_fetch.sv | 120 ++++++++++++
 1 files changed

// File: rtl/gcn_matrix_fetch.sv
// Read initiator for the GCN matrix memory: fetches every weight row, then every
// feature row, and hands each captured row downstream over a valid/ready handshake.
module gcn_matrix_fetch #(
  parameter int WEIGHT_ROWS   = 96,
  parameter int WEIGHT_WIDTH  = 5,
  parameter int WEIGHT_COLS   = 3,
  parameter int FEATURE_ROWS  = 6,
  parameter int ADDRESS_WIDTH = 13,
  parameter logic [ADDRESS_WIDTH-1:0] FEATURE_BASE = 13'h200,
  parameter int IDX_WIDTH = $clog2((WEIGHT_COLS > FEATURE_ROWS) ? WEIGHT_COLS : FEATURE_ROWS)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [WEIGHT_ROWS*WEIGHT_WIDTH-1:0] data_in,
  output logic [ADDRESS_WIDTH-1:0]            read_address,
  output logic                                enable_read,
  output logic                                row_valid,
  input  logic                                row_ready,
  output logic [WEIGHT_ROWS*WEIGHT_WIDTH-1:0] row_data,
  output logic                                row_is_feature,
  output logic [IDX_WIDTH-1:0]                row_index,
  output logic                                busy,
  output logic                                done
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                            state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]          addr_q, addr_d;
  logic                              valid_q, valid_d;
  logic [WEIGHT_ROWS*WEIGHT_WIDTH-1:0] data_q, data_d;
  logic                              tag_feat_q, tag_feat_d;
  logic [IDX_WIDTH-1:0]              tag_idx_q, tag_idx_d;
  // Counter and type describe the row being fetched, which runs one ahead of the emitted tag.
  logic [IDX_WIDTH-1:0]              cnt_q, cnt_d;
  logic                              fetch_feat_q, fetch_feat_d;
  logic                              en;

  assign en = (state_q == FETCH) && (!valid_q || row_ready);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    valid_d      = valid_q;
    data_d       = data_q;
    tag_feat_d   = tag_feat_q;
    tag_idx_d    = tag_idx_q;
    cnt_d        = cnt_q;
    fetch_feat_d = fetch_feat_q;
    case (state_q)
      IDLE: if (start) begin
        state_d      = FETCH;
        addr_d       = '0;
        cnt_d        = '0;
        fetch_feat_d = 1'b0;
        tag_feat_d   = 1'b0;
      end
      FETCH: if (en) begin
        data_d     = data_in;
        valid_d    = 1'b1;
        tag_idx_d  = cnt_q;
        tag_feat_d = fetch_feat_q;
        if (!fetch_feat_q) begin
          if (cnt_q == IDX_WIDTH'(WEIGHT_COLS-1)) begin
            addr_d       = FEATURE_BASE;
            fetch_feat_d = 1'b1;
            cnt_d        = '0;
          end else begin
            addr_d = addr_q + ADDRESS_WIDTH'(1);
            cnt_d  = cnt_q + IDX_WIDTH'(1);
          end
        end else if (cnt_q == IDX_WIDTH'(FEATURE_ROWS-1)) begin
          state_d = DRAIN;  // address stays on the last feature row
        end else begin
          addr_d = addr_q + ADDRESS_WIDTH'(1);
          cnt_d  = cnt_q + IDX_WIDTH'(1);
        end
      end
      DRAIN: if (valid_q && row_ready) begin
        valid_d = 1'b0;
        state_d = DONE;
      end
      DONE: if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      tag_feat_q   <= 1'b0;
      tag_idx_q    <= '0;
      cnt_q        <= '0;
      fetch_feat_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      tag_feat_q   <= tag_feat_d;
      tag_idx_q    <= tag_idx_d;
      cnt_q        <= cnt_d;
      fetch_feat_q <= fetch_feat_d;
    end
  end

  assign read_address   = addr_q;
  assign enable_read    = en;
  assign row_valid      = valid_q;
  assign row_data       = data_q;
  assign row_is_feature = tag_feat_q;
  assign row_index      = tag_idx_q;
  assign busy           = (state_q == FETCH) || (state_q == DRAIN);
  assign done           = (state_q == DONE);

endmodule
